// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared encodings and the per-channel state record used by
//                the multi-channel PWM engine and its configuration store.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Register select field, low two bits of every register address
    localparam logic [1:0] SEL_R    = 2'd0;
    localparam logic [1:0] SEL_F    = 2'd1;
    localparam logic [1:0] SEL_P    = 2'd2;
    localparam logic [1:0] SEL_CTRL = 2'd3;

    // Bit positions inside a channel control word
    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;

    // State fields are sized for the widest supported counter; narrower
    // engines keep the upper bits at zero.
    localparam int CNT_MAX_W = 32;

    typedef logic [CNT_MAX_W-1:0] pwm_cnt_t;

    typedef struct packed {
        pwm_cnt_t next_r;
        pwm_cnt_t next_f;
        pwm_cnt_t next_p;
        logic     level;
    } pwm_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_cfg_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_cfg_regfile
//  Description : Per-channel rise/fall/period/control storage with one write
//                port, a combinational scan read port and a registered
//                readback port.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_cfg_regfile
    import pwm_pkg::*;
#(
    parameter int NCH   = 64,
    parameter int CNT_W = 32
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      i_wr_en,
    input  logic [$clog2(NCH)+1:0]    i_wr_addr,
    input  logic [CNT_W-1:0]          i_wr_data,
    input  logic [$clog2(NCH)-1:0]    i_scan_idx,
    output logic [CNT_W-1:0]          o_scan_r,
    output logic [CNT_W-1:0]          o_scan_f,
    output logic [CNT_W-1:0]          o_scan_p,
    output logic [1:0]                o_scan_ctrl,
    input  logic [$clog2(NCH)+1:0]    i_rd_addr,
    output logic [CNT_W-1:0]          o_rd_data
);

    localparam int CH_W = $clog2(NCH);

    logic [CNT_W-1:0] r_cfg_r    [NCH];
    logic [CNT_W-1:0] r_cfg_f    [NCH];
    logic [CNT_W-1:0] r_cfg_p    [NCH];
    logic [1:0]       r_cfg_ctrl [NCH];

    logic [CH_W-1:0]  w_wr_ch;
    logic [1:0]       w_wr_sel;
    logic             w_wr_ok;
    logic [CH_W-1:0]  w_rd_ch;
    logic [1:0]       w_rd_sel;
    logic [CNT_W-1:0] w_rd_val;

    assign w_wr_ch  = i_wr_addr[CH_W+1:2];
    assign w_wr_sel = i_wr_addr[1:0];
    assign w_wr_ok  = i_wr_en && (int'(w_wr_ch) < NCH);
    assign w_rd_ch  = i_rd_addr[CH_W+1:2];
    assign w_rd_sel = i_rd_addr[1:0];

    // Configuration write; addresses beyond the last channel are dropped
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_cfg_r[i]    <= '0;
                r_cfg_f[i]    <= '0;
                r_cfg_p[i]    <= '0;
                r_cfg_ctrl[i] <= '0;
            end
        end else if (w_wr_ok) begin
            case (w_wr_sel)
                SEL_R:    r_cfg_r[w_wr_ch]    <= i_wr_data;
                SEL_F:    r_cfg_f[w_wr_ch]    <= i_wr_data;
                SEL_P:    r_cfg_p[w_wr_ch]    <= i_wr_data;
                SEL_CTRL: r_cfg_ctrl[w_wr_ch] <= i_wr_data[1:0];
                default:  ;
            endcase
        end
    end

    // Scan port follows the scan index in the same cycle, so a write landing
    // on the same edge as a reload leaves the reload with the old value.
    assign o_scan_r    = r_cfg_r[i_scan_idx];
    assign o_scan_f    = r_cfg_f[i_scan_idx];
    assign o_scan_p    = r_cfg_p[i_scan_idx];
    assign o_scan_ctrl = r_cfg_ctrl[i_scan_idx];

    // Readback mux; unpopulated channels read as zero
    always_comb begin
        w_rd_val = '0;
        if (int'(w_rd_ch) < NCH) begin
            case (w_rd_sel)
                SEL_R:    w_rd_val = r_cfg_r[w_rd_ch];
                SEL_F:    w_rd_val = r_cfg_f[w_rd_ch];
                SEL_P:    w_rd_val = r_cfg_p[w_rd_ch];
                SEL_CTRL: w_rd_val = CNT_W'(r_cfg_ctrl[w_rd_ch]);
                default:  w_rd_val = '0;
            endcase
        end
    end

    // Readback register gives one cycle of latency
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= w_rd_val;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_pwm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : multi_pwm_engine
//  Description : Time-multiplexed PWM generator. One channel is evaluated per
//                clock; a complete scan advances the master tick counter and
//                publishes all channel outputs on a single edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_pwm_engine
    import pwm_pkg::*;
#(
    parameter int NCH   = 64,
    parameter int CNT_W = 32
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      Run,
    input  logic [CNT_W-1:0]          Terminate,
    input  logic                      Wr_En,
    input  logic [$clog2(NCH)+1:0]    Wr_Addr,
    input  logic [CNT_W-1:0]          Wr_Data,
    input  logic [$clog2(NCH)+1:0]    Rd_Addr,
    output logic [CNT_W-1:0]          Rd_Data,
    output logic [NCH-1:0]            Pwm_Out,
    output logic [CNT_W-1:0]          Count,
    output logic                      Scan_Done,
    output logic                      Halted
);

    localparam int              CH_W   = $clog2(NCH);
    localparam logic [CH_W-1:0] c_LAST = CH_W'(NCH - 1);

    logic [CH_W-1:0]  r_scan_idx;
    logic             r_init;
    logic             r_halted;
    logic [CNT_W-1:0] r_count;
    logic [NCH-1:0]   r_buf;
    logic [NCH-1:0]   r_pwm_out;
    pwm_state_t       r_state [NCH];

    logic [CNT_W-1:0] w_cfg_r;
    logic [CNT_W-1:0] w_cfg_f;
    logic [CNT_W-1:0] w_cfg_p;
    logic [1:0]       w_cfg_ctrl;

    logic [CNT_W-1:0] w_sum_r;
    logic [CNT_W-1:0] w_sum_f;
    logic [CNT_W-1:0] w_sum_p;
    pwm_cnt_t         w_cnt_ext;
    pwm_cnt_t         w_eff_r;
    pwm_cnt_t         w_eff_f;
    pwm_cnt_t         w_eff_p;
    pwm_state_t       w_cur;
    pwm_state_t       w_nxt;
    logic             w_live;
    logic             w_period;
    logic             w_rise;
    logic             w_fall;
    logic             w_last;
    logic             w_term_hit;
    logic [NCH-1:0]   w_buf_nxt;

    pwm_cfg_regfile #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) u_cfg (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .i_wr_en     (Wr_En),
        .i_wr_addr   (Wr_Addr),
        .i_wr_data   (Wr_Data),
        .i_scan_idx  (r_scan_idx),
        .o_scan_r    (w_cfg_r),
        .o_scan_f    (w_cfg_f),
        .o_scan_p    (w_cfg_p),
        .o_scan_ctrl (w_cfg_ctrl),
        .i_rd_addr   (Rd_Addr),
        .o_rd_data   (Rd_Data)
    );

    assign w_last     = (r_scan_idx == c_LAST);
    assign w_term_hit = (Terminate != '0) && (r_count == Terminate);
    assign w_cur      = r_state[r_scan_idx];
    assign w_cnt_ext  = pwm_cnt_t'(r_count);

    // Reload targets wrap at the counter width before being widened
    assign w_sum_r = r_count + w_cfg_r;
    assign w_sum_f = r_count + w_cfg_f;
    assign w_sum_p = r_count + w_cfg_p;

    // A channel with a zero period or cleared enable never reloads
    assign w_live   = w_cfg_ctrl[CTRL_EN] && (w_cfg_p != '0);
    assign w_period = w_live && (w_cur.next_p == w_cnt_ext);
    assign w_eff_r  = w_period ? pwm_cnt_t'(w_sum_r) : w_cur.next_r;
    assign w_eff_f  = w_period ? pwm_cnt_t'(w_sum_f) : w_cur.next_f;
    assign w_eff_p  = w_period ? pwm_cnt_t'(w_sum_p) : w_cur.next_p;
    assign w_rise   = w_live && (w_eff_r == w_cnt_ext);
    assign w_fall   = w_live && (w_eff_f == w_cnt_ext);

    // Next state of the channel under evaluation and its output bit
    always_comb begin
        w_nxt     = w_cur;
        w_buf_nxt = r_buf;
        if (r_init) begin
            w_nxt.next_r = pwm_cnt_t'(w_cfg_r);
            w_nxt.next_f = pwm_cnt_t'(w_cfg_f);
            w_nxt.next_p = pwm_cnt_t'(w_cfg_p);
            w_nxt.level  = 1'b0;
        end else begin
            w_nxt.next_r = w_eff_r;
            w_nxt.next_f = w_eff_f;
            w_nxt.next_p = w_eff_p;
            if (!w_live) begin
                w_nxt.level = 1'b0;
            end else if (w_rise) begin
                w_nxt.level = 1'b1;
            end else if (w_fall) begin
                w_nxt.level = 1'b0;
            end
        end
        w_buf_nxt[r_scan_idx] = w_nxt.level ^ w_cfg_ctrl[CTRL_INV];
    end

    // Per-channel state store, cleared whenever the engine is stopped
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= '0;
            end
        end else if (!Run) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= '0;
            end
        end else if (!r_halted) begin
            r_state[r_scan_idx] <= w_nxt;
        end
    end

    // Scan sequencing, tick counter, terminal halt and output publication
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_scan_idx <= '0;
            r_init     <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= '0;
            r_buf      <= '0;
            r_pwm_out  <= '0;
        end else if (!Run) begin
            r_scan_idx <= '0;
            r_init     <= 1'b1;
            r_halted   <= 1'b0;
            r_count    <= '0;
            r_buf      <= '0;
            r_pwm_out  <= '0;
        end else if (!r_halted) begin
            r_buf <= w_buf_nxt;
            if (w_last) begin
                r_scan_idx <= '0;
                r_pwm_out  <= w_buf_nxt;
                if (r_init) begin
                    r_init <= 1'b0;
                end else if (w_term_hit) begin
                    r_halted <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else begin
                r_scan_idx <= r_scan_idx + 1'b1;
            end
        end
    end

    assign Pwm_Out   = r_pwm_out;
    assign Count     = r_count;
    assign Halted    = r_halted;
    assign Scan_Done = Run && !r_halted && w_last;

endmodule
`default_nettype wire

// File: tb/tb_multi_pwm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_pwm_engine
//  Description : Self-checking bench for multi_pwm_engine (4 channels, 8-bit
//                counter) against a tick-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_pwm_engine;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    localparam int MOD   = 256;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Run;
    logic [7:0] Terminate;
    logic       Wr_En;
    logic [3:0] Wr_Addr;
    logic [7:0] Wr_Data;
    logic [3:0] Rd_Addr;
    logic [7:0] Rd_Data;
    logic [3:0] Pwm_Out;
    logic [7:0] Count;
    logic       Scan_Done;
    logic       Halted;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: configuration, per-channel timing and tick state
    int       m_r [NCH];
    int       m_f [NCH];
    int       m_p [NCH];
    bit       m_en [NCH];
    bit       m_inv [NCH];
    int       m_nr [NCH];
    int       m_nf [NCH];
    int       m_np [NCH];
    bit       m_lvl [NCH];
    int       m_count;
    int       m_term;
    bit       m_init;
    bit       m_halted;
    bit       m_eval;
    int       last_eval;
    logic [3:0] m_pwm;
    int       highs[$];

    multi_pwm_engine #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Run       (Run),
        .Terminate (Terminate),
        .Wr_En     (Wr_En),
        .Wr_Addr   (Wr_Addr),
        .Wr_Data   (Wr_Data),
        .Rd_Addr   (Rd_Addr),
        .Rd_Data   (Rd_Data),
        .Pwm_Out   (Pwm_Out),
        .Count     (Count),
        .Scan_Done (Scan_Done),
        .Halted    (Halted)
    );

    always #5 Clk = ~Clk;

    function automatic void model_cfg_clear();
        for (int c = 0; c < NCH; c++) begin
            m_r[c] = 0; m_f[c] = 0; m_p[c] = 0; m_en[c] = 0; m_inv[c] = 0;
        end
    endfunction

    function automatic void model_stop();
        m_count  = 0;
        m_init   = 1;
        m_halted = 0;
        m_pwm    = '0;
        for (int c = 0; c < NCH; c++) begin
            m_nr[c] = 0; m_nf[c] = 0; m_np[c] = 0; m_lvl[c] = 0;
        end
    endfunction

    function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
        int ch = int'(a[3:2]);
        case (a[1:0])
            2'd0: m_r[ch] = int'(d);
            2'd1: m_f[ch] = int'(d);
            2'd2: m_p[ch] = int'(d);
            default: begin m_en[ch] = d[0]; m_inv[ch] = d[1]; end
        endcase
    endfunction

    function automatic int model_read(input logic [3:0] a);
        int ch = int'(a[3:2]);
        case (a[1:0])
            2'd0:    return m_r[ch];
            2'd1:    return m_f[ch];
            2'd2:    return m_p[ch];
            default: return (m_inv[ch] ? 2 : 0) + (m_en[ch] ? 1 : 0);
        endcase
    endfunction

    // One full tick: every channel evaluated at the current Count
    function automatic void model_scan();
        m_eval = 0;
        if (m_halted) return;
        m_eval    = 1;
        last_eval = m_count;
        for (int c = 0; c < NCH; c++) begin
            if (m_init) begin
                m_nr[c] = m_r[c]; m_nf[c] = m_f[c]; m_np[c] = m_p[c]; m_lvl[c] = 0;
            end else if (m_en[c] && m_p[c] != 0) begin
                if (m_np[c] == m_count) begin
                    m_nr[c] = (m_count + m_r[c]) % MOD;
                    m_nf[c] = (m_count + m_f[c]) % MOD;
                    m_np[c] = (m_count + m_p[c]) % MOD;
                end
                if (m_nr[c] == m_count)      m_lvl[c] = 1;
                else if (m_nf[c] == m_count) m_lvl[c] = 0;
            end else begin
                m_lvl[c] = 0;
            end
            m_pwm[c] = m_lvl[c] ^ m_inv[c];
        end
        if (m_init)                                m_init = 0;
        else if (m_term != 0 && m_count == m_term) m_halted = 1;
        else                                       m_count = (m_count + 1) % MOD;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_idle(input logic [3:0] a, input logic [7:0] d);
        Wr_En = 1'b1; Wr_Addr = a; Wr_Data = d;
        step();
        Wr_En = 1'b0;
        model_write(a, d);
    endtask

    task automatic stop_run();
        Run = 1'b0;
        step();
        model_stop();
        check("stop_pwm", 32'(Pwm_Out), 32'd0);
        check("stop_count", 32'(Count), 32'd0);
        check("stop_halted", 32'(Halted), 32'd0);
    endtask

    // One scan worth of clocks with an optional write on the last cycle
    task automatic do_scan(input bit wr, input logic [3:0] wa, input logic [7:0] wd);
        logic [3:0] held;
        logic [3:0] ra;
        bit         was_halted;
        int         rexp;
        held       = Pwm_Out;
        was_halted = m_halted;
        ra         = 4'($urandom_range(0, 15));
        Rd_Addr    = ra;
        rexp       = model_read(ra);
        for (int i = 0; i < NCH; i++) begin
            check("scan_done", 32'(Scan_Done), 32'(!was_halted && i == NCH - 1));
            if (i == NCH - 1 && wr) begin
                Wr_En = 1'b1; Wr_Addr = wa; Wr_Data = wd;
            end
            step();
            Wr_En = 1'b0;
            if (i == 0)       check("readback", 32'(Rd_Data), 32'(rexp));
            if (i < NCH - 1)  check("pwm_hold", 32'(Pwm_Out), 32'(held));
        end
        model_scan();
        if (wr) model_write(wa, wd);
        check("pwm", 32'(Pwm_Out), 32'(m_pwm));
        check("count", 32'(Count), 32'(m_count));
        check("halted", 32'(Halted), 32'(m_halted));
    endtask

    initial begin
        Rst_n = 1'b0; Run = 1'b0; Terminate = '0; Wr_En = 1'b0;
        Wr_Addr = '0; Wr_Data = '0; Rd_Addr = '0;
        m_term = 0;
        model_cfg_clear();
        model_stop();
        step(); step();
        check("rst_pwm", 32'(Pwm_Out), 32'd0);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_scan_done", 32'(Scan_Done), 32'd0);
        check("rst_rd_data", 32'(Rd_Data), 32'd0);
        Rst_n = 1'b1;
        step();

        // Basic waveform, inverted rise-priority channel, terminal halt
        write_idle(4'b0000, 8'd2);  write_idle(4'b0001, 8'd5);
        write_idle(4'b0010, 8'd10); write_idle(4'b0011, 8'd1);
        write_idle(4'b0100, 8'd3);  write_idle(4'b0101, 8'd3);
        write_idle(4'b0110, 8'd8);  write_idle(4'b0111, 8'd3);
        m_term = 20; Terminate = 8'd20;
        Run = 1'b1;
        do_scan(0, '0, '0);
        check("init_pwm", 32'(Pwm_Out), 32'h2);
        for (int s = 0; s < 25; s++) begin
            do_scan(0, '0, '0);
            if (m_eval) begin
                check("ch0_shape", 32'(Pwm_Out[0]), 32'(last_eval % 10 >= 2 && last_eval % 10 <= 4));
                check("ch1_inv", 32'(Pwm_Out[1]), 32'(last_eval < 3));
                check("ch23_off", 32'(Pwm_Out[3:2]), 32'd0);
            end
        end
        check("halt_count", 32'(Count), 32'd20);
        check("halt_flag", 32'(Halted), 32'd1);
        stop_run();

        // Period rewrite mid-period takes effect at the next boundary
        m_term = 0; Terminate = '0;
        write_idle(4'b0111, 8'd0);
        Run = 1'b1;
        do_scan(0, '0, '0);
        for (int s = 0; s < 22; s++) begin
            do_scan(m_count == 6, 4'b0010, 8'd4);
            check("reload_shape", 32'(Pwm_Out[0]),
                  32'(last_eval >= 12 || (last_eval % 10 >= 2 && last_eval % 10 <= 4)));
        end
        stop_run();
        Rd_Addr = 4'b0010;
        step();
        check("readback_p", 32'(Rd_Data), 32'd4);

        // Long period across the counter wrap
        write_idle(4'b0000, 8'd1); write_idle(4'b0001, 8'd2); write_idle(4'b0010, 8'd100);
        Run = 1'b1;
        do_scan(0, '0, '0);
        highs.delete();
        for (int s = 0; s < 310; s++) begin
            do_scan(0, '0, '0);
            if (Pwm_Out[0]) highs.push_back(last_eval);
        end
        check("wrap_high_n", 32'(highs.size()), 32'd4);
        if (highs.size() == 4) begin
            check("wrap_high0", 32'(highs[0]), 32'd1);
            check("wrap_high1", 32'(highs[1]), 32'd101);
            check("wrap_high2", 32'(highs[2]), 32'd201);
            check("wrap_high3", 32'(highs[3]), 32'd45);
        end
        stop_run();

        // Randomised configuration and live writes
        for (int a = 0; a < 16; a++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 30));
            write_idle(4'(a), d);
        end
        m_term    = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(30, 70));
        Terminate = 8'(m_term);
        Run = 1'b1;
        for (int s = 0; s < 80; s++) begin
            do_scan($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 40)));
        end
        stop_run();

        // Asynchronous reset while an output is high
        m_term = 0; Terminate = '0;
        write_idle(4'b1111, 8'd2);
        Run = 1'b1;
        do_scan(0, '0, '0);
        do_scan(0, '0, '0);
        check("pre_reset_ch3", 32'(Pwm_Out[3]), 32'd1);
        step(); step();
        Rst_n = 1'b0;
        #2;
        check("async_pwm", 32'(Pwm_Out), 32'd0);
        check("async_count", 32'(Count), 32'd0);
        check("async_halted", 32'(Halted), 32'd0);
        Run = 1'b0;
        step();
        Rst_n = 1'b1;
        model_cfg_clear();
        model_stop();
        for (int a = 0; a < 16; a++) begin
            Rd_Addr = 4'(a);
            step();
            check("post_reset_cfg", 32'(Rd_Data), 32'(model_read(4'(a))));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
